// File: rtl/microseq_pkg.sv
// Shared definitions for the ROM-dispatch micro-sequencer.
// Widths, sequence-type encoding, jump target and the three lookup tables.
package microseq_pkg;

    localparam int UPC_W   = 4;
    localparam int OP_W    = 2;
    localparam int NUM_UPC = 13;
    localparam int CTRL_W  = 8;

    localparam logic [UPC_W-1:0] UPC_MAX    = UPC_W'(NUM_UPC - 1);
    localparam logic [UPC_W-1:0] JMP_TARGET = 4'd7;

    typedef enum logic [2:0] {
        SEQ_INC   = 3'b000,
        SEQ_DISP1 = 3'b001,
        SEQ_JMP7  = 3'b010,
        SEQ_DISP2 = 3'b011,
        SEQ_RET   = 3'b100
    } seq_type_e;

    // Dispatch targets indexed by opcode.
    localparam logic [UPC_W-1:0] DISP1_TBL [2**OP_W] = '{4'd4, 4'd5, 4'd6, 4'd6};
    localparam logic [UPC_W-1:0] DISP2_TBL [2**OP_W] = '{4'd11, 4'd12, 4'd12, 4'd12};

    // Sequence type of each legal micro-PC entry.
    localparam seq_type_e SEQ_TBL [NUM_UPC] = '{
        SEQ_INC,  SEQ_INC,  SEQ_INC,  SEQ_DISP1,
        SEQ_JMP7, SEQ_JMP7, SEQ_INC,  SEQ_INC,
        SEQ_INC,  SEQ_INC,  SEQ_DISP2, SEQ_RET,
        SEQ_RET
    };

endpackage

// File: rtl/microseq_rom.sv
// Pure lookup: sequence type of a micro-PC and the dispatch target for an opcode.
// Ports: upc/op in; seq_type (RET for out-of-range upc) and disp_target out.
module microseq_rom
    import microseq_pkg::*;
(
    input  logic [UPC_W-1:0] upc,
    input  logic [OP_W-1:0]  op,
    output logic [2:0]       seq_type,
    output logic [UPC_W-1:0] disp_target
);

    always_comb begin
        // Entries past the end of the program behave as a return.
        seq_type = SEQ_RET;
        if (upc <= UPC_MAX) begin
            seq_type = SEQ_TBL[upc];
        end
        if (seq_type == SEQ_DISP2) begin
            disp_target = DISP2_TBL[op];
        end else begin
            disp_target = DISP1_TBL[op];
        end
    end

endmodule

// File: rtl/microseq_ctrl.sv
// Run-control sequencer: owns the micro-PC and IDLE/RUN controller.
// Ports: clk, rst (sync, active-high), start, abort, step_en, step,
//        op_valid/op_data/op_ready dispatch handshake, upc, ctrl_word,
//        busy, done (one-cycle pulse), err (sticky illegal-upc flag).
module microseq_ctrl
    import microseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              step_en,
    input  logic              step,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   op_data,
    output logic              op_ready,
    output logic [UPC_W-1:0]  upc,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [2:0]       seq_type;
    logic [UPC_W-1:0] disp_target;
    logic             run;
    logic             adv;
    logic             is_disp;
    logic             illegal;
    logic             op_wait;
    logic             xfer;

    microseq_rom u_rom (
        .upc         (upc_q),
        .op          (op_data),
        .seq_type    (seq_type),
        .disp_target (disp_target)
    );

    assign run     = (state_q == ST_RUN);
    assign adv     = step_en ? step : 1'b1;
    assign is_disp = (seq_type == SEQ_DISP1) || (seq_type == SEQ_DISP2);
    assign illegal = (upc_q > UPC_MAX);

    // Abort and reset both suppress the transfer in the cycle they occur.
    assign op_ready = run & adv & is_disp & ~abort & ~rst;
    assign op_wait  = run & is_disp & ~op_valid;
    assign xfer     = op_valid & op_ready;

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q | illegal;
        if (abort) begin
            state_d = ST_IDLE;
            upc_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    upc_d  = '0;
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (is_disp) begin
                        // Without a transfer the dispatch stalls; a step is lost.
                        if (xfer) begin
                            upc_d = disp_target;
                        end
                    end else if (adv) begin
                        case (seq_type)
                            SEQ_INC:  upc_d = upc_q + UPC_W'(1);
                            SEQ_JMP7: upc_d = JMP_TARGET;
                            default: begin
                                // RET, and any illegal upc (no done pulse).
                                state_d = ST_IDLE;
                                upc_d   = '0;
                                busy_d  = 1'b0;
                                done_d  = ~illegal;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    upc_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign upc       = upc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ctrl_word = {seq_type, op_wait, upc_q};

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural program model.
module tb_microseq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       step_en = 1'b0;
    logic       step = 1'b0;
    logic       op_valid = 1'b0;
    logic [1:0] op_data = 2'd0;
    logic       op_ready;
    logic [3:0] upc;
    logic [7:0] ctrl_word;
    logic       busy;
    logic       done;
    logic       err;

    microseq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .step_en   (step_en),
        .step      (step),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .upc       (upc),
        .ctrl_word (ctrl_word),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int xfers = 0;
    int busy_cnt = 0;

    // Program model: running flag, program counter, pulses.
    logic       m_run = 1'b0;
    logic [3:0] m_pc = 4'd0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;

    typedef struct {
        logic       st;
        logic [1:0] od;
        logic [3:0] e_upc;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic st, input logic [1:0] od,
                                input logic [3:0] u, input logic b,
                                input logic d);
        vec_t v;
        v.st = st;
        v.od = od;
        v.e_upc = u;
        v.e_busy = b;
        v.e_done = d;
        return v;
    endfunction

    function automatic logic [2:0] seq_code(input logic [3:0] pc);
        if (pc <= 2 || (pc >= 6 && pc <= 9)) return 3'b000;
        if (pc == 3) return 3'b001;
        if (pc == 4 || pc == 5) return 3'b010;
        if (pc == 10) return 3'b011;
        return 3'b100;
    endfunction

    function automatic logic [3:0] disp_tgt(input logic [3:0] pc,
                                            input logic [1:0] op);
        if (pc == 3) begin
            if (op == 0) return 4'd4;
            if (op == 1) return 4'd5;
            return 4'd6;
        end
        if (op == 0) return 4'd11;
        return 4'd12;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic ab,
                       input logic se, input logic sp, input logic ov,
                       input logic [1:0] od);
        logic adv, disp, rdy, wt;
        @(negedge clk);
        rst = r;
        start = st;
        abort = ab;
        step_en = se;
        step = sp;
        op_valid = ov;
        op_data = od;
        #1;
        adv = se ? sp : 1'b1;
        disp = (m_pc == 3) || (m_pc == 10);
        rdy = m_run && adv && disp && !ab && !r;
        wt = m_run && disp && !ov;
        chk("op_ready", op_ready, rdy);
        chk("ctrl_word", ctrl_word, {seq_code(m_pc), wt, m_pc});
        if (ov && op_ready) xfers++;
        @(posedge clk);
        if (r) begin
            m_run = 0;
            m_pc = 0;
            m_err = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_pc >= 13) m_err = 1;
            if (ab) begin
                m_run = 0;
                m_pc = 0;
            end else if (!m_run) begin
                m_pc = 0;
                if (st) m_run = 1;
            end else if (disp) begin
                if (ov && rdy) m_pc = disp_tgt(m_pc, od);
            end else if (adv) begin
                if (m_pc >= 11) begin
                    m_done = (m_pc < 13);
                    m_run = 0;
                    m_pc = 0;
                end else if (m_pc == 4 || m_pc == 5) begin
                    m_pc = 7;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
        #1;
        chk("upc", upc, m_pc);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("err", err, m_err);
        if (busy) busy_cnt++;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 40) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            n++;
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic run_to(input logic [3:0] target);
        int n = 0;
        while (upc != target && n < 30) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            n++;
        end
        chk("reach_upc", upc, target);
    endtask

    initial begin
        logic [3:0] prev;
        logic       sp;
        logic       se;
        int         k;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_upc", upc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 0);

        // Free-run, opcode 0 at both dispatches.
        tv.push_back(mk(1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 0));
        tv.push_back(mk(0, 0, 2, 1, 0));
        tv.push_back(mk(0, 0, 3, 1, 0));
        tv.push_back(mk(0, 0, 4, 1, 0));
        tv.push_back(mk(0, 0, 7, 1, 0));
        tv.push_back(mk(0, 0, 8, 1, 0));
        tv.push_back(mk(0, 0, 9, 1, 0));
        tv.push_back(mk(0, 0, 10, 1, 0));
        tv.push_back(mk(0, 0, 11, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0));
        // Free-run, opcode 2 then 3.
        tv.push_back(mk(1, 2, 0, 1, 0));
        tv.push_back(mk(0, 2, 1, 1, 0));
        tv.push_back(mk(0, 2, 2, 1, 0));
        tv.push_back(mk(0, 2, 3, 1, 0));
        tv.push_back(mk(0, 2, 6, 1, 0));
        tv.push_back(mk(0, 3, 7, 1, 0));
        tv.push_back(mk(0, 3, 8, 1, 0));
        tv.push_back(mk(0, 3, 9, 1, 0));
        tv.push_back(mk(0, 3, 10, 1, 0));
        tv.push_back(mk(0, 3, 12, 1, 0));
        tv.push_back(mk(0, 3, 0, 0, 1));
        tv.push_back(mk(0, 3, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            if (i == 0 || i == 12) begin
                xfers = 0;
                busy_cnt = 0;
            end
            cyc(0, tv[i].st, 0, 0, 0, 1, tv[i].od);
            chk("tv_upc", upc, tv[i].e_upc);
            chk("tv_busy", busy, tv[i].e_busy);
            chk("tv_done", done, tv[i].e_done);
            if (i == 11 || i == 23) begin
                chk("tv_xfers", xfers, 2);
                chk("tv_busy_cycles", busy_cnt, 10);
            end
        end

        // Dispatch stall at upc 3.
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("stall_upc", upc, 3);
            chk("stall_wait", ctrl_word[4], 1);
            chk("stall_ready", op_ready, 1);
        end
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("stall_go", upc, 5);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("stall_jmp", upc, 7);
        drain();

        // Single-step: pulse every third cycle until upc reaches 10.
        cyc(0, 1, 0, 1, 0, 1, 0);
        k = 0;
        while (upc != 10 && k < 60) begin
            sp = (k % 3 == 2);
            prev = upc;
            cyc(0, 0, 0, 1, sp, 1, 0);
            chk("step_move", (upc != prev), sp);
            k++;
        end
        chk("step_at10", upc, 10);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("step_no_op", upc, 10);
        cyc(0, 0, 0, 1, 0, 1, 3);
        chk("step_no_pulse", upc, 10);
        cyc(0, 0, 0, 1, 1, 1, 0);
        chk("step_disp2", upc, 11);
        cyc(0, 0, 0, 1, 1, 1, 0);
        chk("step_done", done, 1);

        // Abort mid-run, then abort together with start.
        cyc(0, 1, 0, 0, 0, 1, 0);
        run_to(8);
        cyc(0, 0, 1, 0, 0, 1, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_upc", upc, 0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        chk("abort_start_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("abort_start_idle", busy, 0);

        // Fault-injected illegal upc.
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        force dut.upc_q = 4'd14;
        #1;
        release dut.upc_q;
        m_pc = 4'd14;
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("illegal_err", err, 1);
        chk("illegal_upc", upc, 0);
        chk("illegal_done", done, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        drain();
        chk("err_sticky", err, 1);

        // Reset for two cycles mid-run.
        cyc(0, 1, 0, 0, 0, 1, 0);
        run_to(8);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("rst_mid_upc", upc, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_err", err, 0);

        // Randomized traffic against the model.
        se = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) se = $urandom_range(0, 1) != 0;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 40) == 0),
                se,
                ($urandom_range(0, 1) != 0),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
